// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: owns PCF, fetches over a req/ack handshake and drives the IF/ID register.
// Optional FETCH_DELAY_SLOT_EN: branch delay slot (redirect delivered after the sequential instruction).
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        PCSrcD,
  input  logic [31:0] PCBranchD,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] InstrD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t      state, state_n, after;
  logic [31:0] pcf, pcf_n, pc_plus4, seq_next;
  logic [31:0] hold, hold_n;
  logic [31:0] deliver_instr;
  logic        deliver;
  logic        redirect;
  logic        waiting;

`ifdef FETCH_DELAY_SLOT_EN
  logic        pend_valid, pend_valid_n;
  logic [31:0] pend_target, pend_target_n;
`else
  logic        drop, drop_n;
`endif

  assign pc_plus4 = pcf + 32'd4;
  assign redirect = PCSrcD & ValidD & ~StallD;
  assign waiting  = (state == BUSY) && !imem_ack;
  assign after    = StallF ? IDLE : BUSY;

`ifdef FETCH_DELAY_SLOT_EN
  assign seq_next = redirect ? PCBranchD : (pend_valid ? pend_target : pc_plus4);
`else
  assign seq_next = pc_plus4;
`endif

  always_comb begin
    state_n       = state;
    pcf_n         = pcf;
    hold_n        = hold;
    deliver       = 1'b0;
    deliver_instr = '0;
`ifdef FETCH_DELAY_SLOT_EN
    pend_valid_n  = pend_valid;
    pend_target_n = pend_target;
`else
    drop_n        = drop;
`endif

    unique case (state)
      IDLE: if (!StallF) state_n = BUSY;
      BUSY: begin
        if (imem_ack) begin
`ifndef FETCH_DELAY_SLOT_EN
          if (drop) begin
            drop_n  = 1'b0;
            state_n = after;
          end else
`endif
          if (StallD) begin
            hold_n  = imem_rdata;
            state_n = HOLD;
          end else begin
            deliver       = 1'b1;
            deliver_instr = imem_rdata;
            pcf_n         = seq_next;
            state_n       = after;
          end
        end
      end
      HOLD: begin
        if (!StallD) begin
          deliver       = 1'b1;
          deliver_instr = hold;
          pcf_n         = seq_next;
          state_n       = after;
        end
      end
      default: state_n = IDLE;
    endcase

`ifdef FETCH_DELAY_SLOT_EN
    // The delivered instruction is the delay slot; target waits until it has been acked.
    if (deliver) pend_valid_n = 1'b0;
    if (redirect && !deliver) begin
      pend_valid_n  = 1'b1;
      pend_target_n = PCBranchD;
    end
`else
    // Redirect squashes; an outstanding request still completes and its data is dropped.
    if (redirect) begin
      pcf_n         = PCBranchD;
      deliver       = 1'b0;
      deliver_instr = '0;
      if (waiting) drop_n = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      pcf       <= RESET_PC;
      hold      <= '0;
      imem_req  <= 1'b0;
      imem_addr <= RESET_PC;
      InstrD    <= '0;
      PCPlus4D  <= '0;
      ValidD    <= 1'b0;
`ifdef FETCH_DELAY_SLOT_EN
      pend_valid  <= 1'b0;
      pend_target <= '0;
`else
      drop      <= 1'b0;
`endif
    end else begin
      state    <= state_n;
      pcf      <= pcf_n;
      hold     <= hold_n;
      imem_req <= (state_n == BUSY);
      // Address stays on the bus until the ack even if PCF was redirected meanwhile.
      if (!waiting) imem_addr <= pcf_n;
      if (!StallD) begin
        ValidD <= deliver;
        InstrD <= deliver ? deliver_instr : '0;
        if (deliver) PCPlus4D <= pc_plus4;
      end
`ifdef FETCH_DELAY_SLOT_EN
      pend_valid  <= pend_valid_n;
      pend_target <= pend_target_n;
`else
      drop      <= drop_n;
`endif
    end
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the 5-stage MIPS pipeline: owns PCF, issues requests to instruction memory over a req/ack handshake, and drives the IF/ID pipeline register (InstrD, PCPlus4D, ValidD) consumed by decode and the hazard unit. It honours StallF/StallD from the hazard unit and redirects on taken branches (PCSrcD/PCBranchD) resolved in decode. It tolerates variable-latency memory by holding an acknowledged instruction while decode is stalled.

## Interface
- RESET_PC, 32'h0000_0000, PCF value loaded on reset.
- clk  in  1  pipeline clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- StallF  in  1  hazard unit: do not start a new fetch.
- StallD  in  1  hazard unit: IF/ID register must hold.
- PCSrcD  in  1  taken branch/jump in decode.
- PCBranchD  in  32  redirect target.
- imem_req  out  1  request valid (registered).
- imem_addr  out  32  request address (= PCF).
- imem_ack  in  1  memory returns imem_rdata this cycle.
- imem_rdata  in  32  instruction word.
- InstrD  out  32  IF/ID instruction (0 = nop when invalid).
- PCPlus4D  out  32  IF/ID PC+4.
- ValidD  out  1  IF/ID holds a real instruction.

## Operation
- States: IDLE (no request), BUSY (imem_req=1, waiting ack), HOLD (instruction captured in hold register, decode stalled).
- Reset: state IDLE, PCF=RESET_PC, imem_req=0, InstrD=0, PCPlus4D=0, ValidD=0, hold register=0, drop flag=0.
- IDLE: !StallF -> BUSY; else stay.
- BUSY, imem_ack=0: imem_addr held stable at PCF; if !StallD, IF/ID loads bubble (ValidD=0, InstrD=0).
- BUSY, imem_ack=1, drop=0, !StallD: InstrD<=imem_rdata, PCPlus4D<=PCF+4, ValidD<=1, PCF<=PCF+4; next BUSY if !StallF else IDLE.
- BUSY, imem_ack=1, StallD: hold<=imem_rdata, PCF<=PCF+4 not yet applied; next HOLD.
- BUSY, imem_ack=1, drop=1: rdata discarded, drop<=0; next BUSY at current PCF (already target) unless StallF -> IDLE.
- HOLD: imem_req=0; when !StallD, IF/ID loads hold, PCPlus4D<=PCF+4, PCF<=PCF+4; next BUSY (IDLE if StallF).
- Redirect = PCSrcD & ValidD & !StallD; overrides all other PCF updates: PCF<=PCBranchD, IF/ID<=bubble.
  - In BUSY without ack: drop<=1 (request already on bus completes, then discarded).
  - In BUSY with ack, or HOLD: instruction discarded; next BUSY (IDLE if StallF).
- PC arithmetic modulo 2^32; PCF+4 wraps 32'hFFFF_FFFC -> 0.
- reset overrides everything including an outstanding request; memory must tolerate abandoned request.

## Timing
- imem_req, imem_addr registered; first request one cycle after reset deasserts.
- Zero-wait memory (ack in first BUSY cycle): one instruction per cycle, InstrD valid the cycle after ack.
- imem_req/imem_addr stable from assertion until the ack cycle inclusive; may present next address the following cycle.
- StallD freezes InstrD/PCPlus4D/ValidD exactly; no output changes while StallD=1.

## Configuration
- FETCH_DELAY_SLOT_EN defined: MIPS branch delay slot. Redirect does not squash: sequential instruction (in flight, held, or next fetched) is delivered to IF/ID, target stored in pending-redirect register and loaded into PCF after that instruction's ack; drop flag unused.
- Undefined: squash behaviour as in Operation.

## Test plan
- Reset with RESET_PC=32'h0000_0100, zero-wait memory -> imem_addr 0x100,0x104,0x108 on consecutive cycles; PCPlus4D 0x104,0x108 with ValidD=1.
- ack delayed 3 cycles on 0x104 -> imem_addr stable 3 cycles, ValidD=0 bubbles, then InstrD=rdata, PCPlus4D=0x108.
- StallD=StallF=1 for 2 cycles at ack -> HOLD, imem_req=0, IF/ID unchanged; on release held word appears, next request 0x108.
- PCSrcD=1, PCBranchD=0x200 while 0x10C pending unacked -> 0x10C data dropped, next request 0x200, no ValidD for 0x10C (with FETCH_DELAY_SLOT_EN: 0x10C delivered, then 0x200).
- Wrap: PCF=32'hFFFF_FFFC acked -> PCPlus4D=0, next imem_addr=0.
- reset asserted mid-BUSY -> next cycle imem_req=0, ValidD=0, InstrD=0, PCF=RESET_PC.
